// File: rtl/conv_seq_pkg.sv
// Shared definitions for the convolution layer sequencer: phase encodings
// seen by the conv unit and the parameter-buffer select codes.
package conv_seq_pkg;

    localparam int STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_LOAD_B = 3'd2,
        S_CONV   = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic PARAM_SEL_W = 1'b0;
    localparam logic PARAM_SEL_B = 1'b1;

endpackage

// File: rtl/conv_seq_watchdog.sv
// Per-phase watchdog: cleared on every phase entry, counts while enabled,
// flags expiry on the cycle the count would reach TIMEOUT_CYCLES.
module conv_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expiry always forces a phase exit, so the counter never wraps.
    assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/conv_layer_seq.sv
// Layer-level initiator for the conv unit: fetches weights then biases per
// layer, holds CONV until the unit signals completion, drains, and repeats.
module conv_layer_seq #(
    parameter int LAYER_W        = 3,
    parameter int STATE_WIDTH    = 3,
    parameter int DRAIN_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [LAYER_W-1:0]     layer_num,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [STATE_WIDTH-1:0] current_state,
    input  logic                   state_rst,
    output logic                   param_rd_req,
    output logic                   param_rd_sel,
    output logic [LAYER_W-1:0]     param_rd_layer,
    input  logic                   param_rd_valid,
    output logic                   MAC_weight_valid_in,
    output logic                   MAC_bias_valid_in
);

    import conv_seq_pkg::*;

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LAYER_W-1:0]   r_layer_cnt;
    logic [LAYER_W-1:0]   r_layers;
    logic [DRAIN_W-1:0]   r_drain;
    logic                 r_req;
    logic                 r_wstrb;
    logic                 r_bstrb;
    logic                 r_error;
    logic                 w_accept;
    logic                 w_set_err;
    logic                 w_wstrb;
    logic                 w_bstrb;
    logic                 w_last;
    logic                 w_expire;
    logic                 w_wd_en;
    logic                 w_wd_clr;

    assign w_last   = (r_layer_cnt == r_layers - 1'b1);
    assign w_wd_en  = (r_state == S_LOAD_W) || (r_state == S_LOAD_B) || (r_state == S_CONV);
    assign w_wd_clr = (w_state_nxt != r_state);

    conv_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rstn     (rstn),
        .i_clr    (w_wd_clr),
        .i_en     (w_wd_en),
        .o_expire (w_expire)
    );

    // Handshake inputs are tested before expiry so a late response still wins.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_set_err   = 1'b0;
        w_wstrb     = 1'b0;
        w_bstrb     = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_accept    = 1'b1;
                        w_state_nxt = (layer_num != '0) ? S_LOAD_W : S_DONE;
                    end
                end
                S_LOAD_W: begin
                    if (param_rd_valid) begin
                        w_wstrb     = 1'b1;
                        w_state_nxt = S_LOAD_B;
                    end else if (w_expire) begin
                        w_set_err   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_LOAD_B: begin
                    if (param_rd_valid) begin
                        w_bstrb     = 1'b1;
                        w_state_nxt = S_CONV;
                    end else if (w_expire) begin
                        w_set_err   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_CONV: begin
                    if (state_rst) begin
                        w_state_nxt = S_DRAIN;
                    end else if (w_expire) begin
                        w_set_err   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == '0) begin
                        w_state_nxt = w_last ? S_DONE : S_LOAD_W;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_layer_cnt <= '0;
            r_layers    <= '0;
            r_drain     <= '0;
            r_req       <= 1'b0;
            r_wstrb     <= 1'b0;
            r_bstrb     <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // One fetch request per load-phase entry, raised on its first cycle.
            r_req   <= w_wd_clr && ((w_state_nxt == S_LOAD_W) || (w_state_nxt == S_LOAD_B));
            r_wstrb <= w_wstrb;
            r_bstrb <= w_bstrb;
            if (w_accept) begin
                r_layer_cnt <= '0;
                r_layers    <= layer_num;
            end else if ((r_state == S_DRAIN) && (w_state_nxt == S_LOAD_W)) begin
                r_layer_cnt <= r_layer_cnt + 1'b1;
            end
            if (w_accept) begin
                r_error <= 1'b0;
            end else if (w_set_err) begin
                r_error <= 1'b1;
            end
            if ((r_state == S_CONV) && (w_state_nxt == S_DRAIN)) begin
                r_drain <= DRAIN_W'(DRAIN_CYCLES - 1);
            end else if ((r_state == S_DRAIN) && (r_drain != '0)) begin
                r_drain <= r_drain - 1'b1;
            end
        end
    end

    assign busy                = (r_state != S_IDLE);
    assign done                = (r_state == S_DONE);
    assign error               = r_error;
    assign current_state       = STATE_WIDTH'(r_state);
    assign param_rd_req        = r_req;
    assign param_rd_sel        = (r_state == S_LOAD_B) ? PARAM_SEL_B : PARAM_SEL_W;
    assign param_rd_layer      = r_layer_cnt;
    assign MAC_weight_valid_in = r_wstrb;
    assign MAC_bias_valid_in   = r_bstrb;

endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench for conv_layer_seq: a default-timeout instance for the
// layer sequencing cases and a short-timeout instance for the watchdog cases.
module tb_conv_layer_seq;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0, abort = 1'b0, state_rst = 1'b0, param_rd_valid = 1'b0;
    logic [2:0] layer_num = 3'd0;
    logic       busy, done, error, req, sel, wstrb, bstrb;
    logic [2:0] cur_state, layer;

    logic       t_start = 1'b0, t_abort = 1'b0, t_state_rst = 1'b0, t_valid = 1'b0;
    logic [2:0] t_layer_num = 3'd0;
    logic       t_busy, t_done, t_error, t_req, t_sel, t_wstrb, t_bstrb;
    logic [2:0] t_state, t_layer;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conv_layer_seq u_dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .layer_num(layer_num),
        .busy(busy), .done(done), .error(error), .current_state(cur_state),
        .state_rst(state_rst), .param_rd_req(req), .param_rd_sel(sel),
        .param_rd_layer(layer), .param_rd_valid(param_rd_valid),
        .MAC_weight_valid_in(wstrb), .MAC_bias_valid_in(bstrb)
    );

    conv_layer_seq #(.TIMEOUT_CYCLES(16)) u_dut_to (
        .clk(clk), .rstn(rstn), .start(t_start), .abort(t_abort), .layer_num(t_layer_num),
        .busy(t_busy), .done(t_done), .error(t_error), .current_state(t_state),
        .state_rst(t_state_rst), .param_rd_req(t_req), .param_rd_sel(t_sel),
        .param_rd_layer(t_layer), .param_rd_valid(t_valid),
        .MAC_weight_valid_in(t_wstrb), .MAC_bias_valid_in(t_bstrb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [2:0] st, input logic bsy,
                            input logic dn, input logic er, input logic rq, input logic sl,
                            input logic [2:0] ly, input logic ws, input logic bs);
        chk({tag, "_state"}, st, 0);
        chk({tag, "_busy"}, bsy, 0);
        chk({tag, "_done"}, dn, 0);
        chk({tag, "_error"}, er, 0);
        chk({tag, "_req"}, rq, 0);
        chk({tag, "_sel"}, sl, 0);
        chk({tag, "_layer"}, ly, 0);
        chk({tag, "_wstrb"}, ws, 0);
        chk({tag, "_bstrb"}, bs, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int q_st[$];
        int q_lay[$];
        int exp_st[10] = '{1, 2, 3, 4, 1, 2, 3, 4, 5, 0};
        int exp_lay[4] = '{0, 0, 1, 1};
        int nw, nb, nd, novl, prev, req_wait, conv_wait, ncv, tdone;

        #22 rstn = 1'b1;
        #1;
        chk_idle("rst", cur_state, busy, done, error, req, sel, layer, wstrb, bstrb);
        chk_idle("rst_to", t_state, t_busy, t_done, t_error, t_req, t_sel, t_layer, t_wstrb, t_bstrb);

        // Two-layer run with valid 3 cycles after each req, state_rst 20 cycles into CONV.
        tick();
        start = 1'b1; layer_num = 3'd2;
        tick();
        start = 1'b0; layer_num = 3'd0;
        nw = 0; nb = 0; nd = 0; novl = 0; prev = 0; req_wait = -1; conv_wait = -1;
        for (int c = 0; c < 400 && q_st.size() < 10; c++) begin
            if (int'(cur_state) != prev) begin
                q_st.push_back(int'(cur_state));
                prev = int'(cur_state);
                if (cur_state == 3'd3) conv_wait = 21;
            end
            nw += int'(wstrb); nb += int'(bstrb); nd += int'(done);
            if (wstrb && bstrb) novl++;
            param_rd_valid = 1'b0; state_rst = 1'b0;
            if (req_wait > 0) begin
                req_wait--;
                if (req_wait == 0) begin param_rd_valid = 1'b1; req_wait = -1; end
            end
            if (conv_wait > 0) begin
                conv_wait--;
                if (conv_wait == 0) begin state_rst = 1'b1; conv_wait = -1; end
            end
            if (req) begin
                q_lay.push_back(int'(layer));
                req_wait = 3;
            end
            tick();
        end
        param_rd_valid = 1'b0; state_rst = 1'b0;
        chk("run_state_count", q_st.size(), 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("run_state%0d", i), (i < q_st.size()) ? q_st[i] : -1, exp_st[i]);
        chk("run_req_count", q_lay.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("run_req_layer%0d", i), (i < q_lay.size()) ? q_lay[i] : -1, exp_lay[i]);
        chk("run_wstrb_count", nw, 2);
        chk("run_bstrb_count", nb, 2);
        chk("run_done_count", nd, 1);
        chk("run_strobe_overlap", novl, 0);

        // layer_num == 0: straight to DONE with no fetch.
        start = 1'b1; layer_num = 3'd0;
        tick();
        start = 1'b0;
        chk("zero_state", cur_state, 5);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 1);
        chk("zero_req", req, 0);
        tick();
        chk("zero_state_after", cur_state, 0);
        chk("zero_done_after", done, 0);
        chk("zero_busy_after", busy, 0);

        // Spurious state_rst in LOAD_W and valid in CONV, then abort in DRAIN.
        start = 1'b1; layer_num = 3'd1;
        tick();
        start = 1'b0;
        chk("sp_loadw_state", cur_state, 1);
        chk("sp_loadw_req", req, 1);
        chk("sp_loadw_sel", sel, 0);
        state_rst = 1'b1;
        tick();
        state_rst = 1'b0;
        chk("sp_rst_state", cur_state, 1);
        chk("sp_rst_req", req, 0);
        chk("sp_rst_wstrb", wstrb, 0);
        param_rd_valid = 1'b1;
        tick();
        chk("sp_loadb_state", cur_state, 2);
        chk("sp_loadb_wstrb", wstrb, 1);
        chk("sp_loadb_req", req, 1);
        chk("sp_loadb_sel", sel, 1);
        tick();
        chk("sp_conv_state", cur_state, 3);
        chk("sp_conv_bstrb", bstrb, 1);
        chk("sp_conv_wstrb", wstrb, 0);
        tick();
        param_rd_valid = 1'b0;
        chk("sp_valid_state", cur_state, 3);
        chk("sp_valid_bstrb", bstrb, 0);
        chk("sp_valid_wstrb", wstrb, 0);
        state_rst = 1'b1;
        tick();
        state_rst = 1'b0;
        chk("sp_drain_state", cur_state, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_drain_state", cur_state, 0);
        chk("ab_drain_done", done, 0);
        chk("ab_drain_busy", busy, 0);

        // Abort in LOAD_B on the same cycle as param_rd_valid.
        start = 1'b1; layer_num = 3'd1;
        tick();
        start = 1'b0;
        param_rd_valid = 1'b1;
        tick();
        chk("ab_loadb_state0", cur_state, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0; param_rd_valid = 1'b0;
        chk("ab_loadb_state", cur_state, 0);
        chk("ab_loadb_bstrb", bstrb, 0);
        chk("ab_loadb_req", req, 0);
        chk("ab_loadb_error", error, 0);
        tick();
        chk("ab_loadb_bstrb_late", bstrb, 0);

        // Start while busy is ignored; async reset mid-CONV clears everything.
        start = 1'b1; layer_num = 3'd1;
        tick();
        start = 1'b0;
        param_rd_valid = 1'b1;
        tick();
        tick();
        param_rd_valid = 1'b0;
        chk("busy_conv_state", cur_state, 3);
        start = 1'b1; layer_num = 3'd5;
        tick();
        start = 1'b0; layer_num = 3'd0;
        chk("busy_start_state", cur_state, 3);
        chk("busy_start_req", req, 0);
        rstn = 1'b0;
        #2;
        chk_idle("rst_conv", cur_state, busy, done, error, req, sel, layer, wstrb, bstrb);
        rstn = 1'b1;
        tick();
        start = 1'b1; layer_num = 3'd1;
        tick();
        start = 1'b0;
        chk("rst_pend_state0", cur_state, 1);
        param_rd_valid = 1'b1;
        rstn = 1'b0;
        #2;
        param_rd_valid = 1'b0;
        rstn = 1'b1;
        tick();
        chk("rst_pend_wstrb", wstrb, 0);
        chk("rst_pend_state", cur_state, 0);

        // Watchdog (TIMEOUT_CYCLES=16): no state_rst in CONV.
        t_start = 1'b1; t_layer_num = 3'd1;
        tick();
        t_start = 1'b0;
        t_valid = 1'b1;
        tick();
        tick();
        t_valid = 1'b0;
        chk("to_conv_state", t_state, 3);
        ncv = 0; tdone = 0;
        while (t_state == 3'd3 && ncv < 40) begin
            ncv++;
            tick();
            tdone += int'(t_done);
        end
        chk("to_conv_cycles", ncv, 16);
        chk("to_state", t_state, 0);
        chk("to_error", t_error, 1);
        chk("to_done_count", tdone, 0);
        tick();
        chk("to_error_sticky", t_error, 1);

        // Next start clears error; valid on the expiry cycle wins.
        t_start = 1'b1; t_layer_num = 3'd1;
        tick();
        t_start = 1'b0;
        chk("to_restart_error", t_error, 0);
        chk("to_restart_state", t_state, 1);
        for (int i = 0; i < 15; i++) tick();
        chk("to_edge_state", t_state, 1);
        t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        chk("to_edge_win_state", t_state, 2);
        chk("to_edge_win_error", t_error, 0);
        chk("to_edge_win_wstrb", t_wstrb, 1);
        t_abort = 1'b1;
        tick();
        t_abort = 1'b0;
        chk("to_abort_state", t_state, 0);
        chk("to_abort_bstrb", t_bstrb, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
